// File: rtl/cache_mem_ctrl.sv
// -----------------------------------------------------------------------------
// cache_mem_ctrl
// Memory-side responder for the caches request bus. It takes instruction reads
// (iREN/iaddr) and data reads/writes (dREN/dWEN/daddr/dstore) and arbitrates
// them onto one single-ported RAM. A request completes when iwait or dwait
// drops to 0 for exactly one cycle, and the load data is valid in that cycle.
//
// Ports
//   CLK, nRST          clock and synchronous active-low reset
//   iREN, iaddr        instruction read request (level) and address
//   dREN, dWEN         data read / write request (level); a write wins over a read
//   daddr, dstore      data address and write data
//   iwait, dwait       0 only in the completion cycle of that side
//   iload, dload       read data, held between completions
//   ramREN, ramWEN     RAM read / write strobes
//   ramaddr, ramstore  RAM address and write data
//   ramload, ram_ready RAM read data and access-done indication
//   timeout_err        one-cycle pulse when an access is force-completed
//   icount, dcount     completion counters (only with ACCESS_COUNT_EN)
//
// Optional feature: define ACCESS_COUNT_EN to add the icount/dcount outputs.
// With the macro undefined those ports and counters do not exist, and all other
// behaviour is the same.
//
// Parameters
//   ADDR_W   address width
//   DATA_W   data width (a multiple of 32)
//   TIMEOUT  number of access cycles without ram_ready before a forced
//            completion; 0 disables the timeout
// -----------------------------------------------------------------------------
module cache_mem_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              iwait,
  output logic              dwait,
  output logic [DATA_W-1:0] iload,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
`ifdef ACCESS_COUNT_EN
  output logic [31:0]       icount,
  output logic [31:0]       dcount,
`endif
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } state_t;

  // The counter only needs to reach TIMEOUT-1.
  localparam int                 TCNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int                 TLIM     = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [TCNT_W-1:0]  TLIM_V   = TCNT_W'(TLIM);
  localparam logic [DATA_W-1:0]  BAD_WORD = {(DATA_W/32){32'hBAD1BAD1}};

  state_t              state_r;
  state_t              state_next_s;
  logic                last_d_r;
  logic [TCNT_W-1:0]   tcnt_r;
  logic [DATA_W-1:0]   iload_r;
  logic [DATA_W-1:0]   dload_r;

  logic                dreq_s;
  logic                active_s;
  logic                hit_limit_s;
  logic                done_ok_s;
  logic                done_to_s;
  logic                i_done_s;
  logic                d_done_s;
  logic                d_load_upd_s;
  logic [DATA_W-1:0]   ret_data_s;

  assign dreq_s = dREN | dWEN;

  // Completion qualifiers: the granted requester must still be asserting, and
  // reset being held this cycle aborts the access with no completion.
  always_comb begin
    active_s = 1'b0;
    if (!nRST) begin
      active_s = 1'b0;
    end else if (state_r == IACC) begin
      active_s = iREN;
    end else if (state_r == DACC) begin
      active_s = dreq_s;
    end else begin
      active_s = 1'b0;
    end
  end

  assign hit_limit_s  = (TIMEOUT != 0) && (tcnt_r == TLIM_V);
  // A ready in the timeout cycle is a normal completion.
  assign done_ok_s    = active_s && ram_ready;
  assign done_to_s    = active_s && !ram_ready && hit_limit_s;
  assign i_done_s     = (done_ok_s || done_to_s) && (state_r == IACC);
  assign d_done_s     = (done_ok_s || done_to_s) && (state_r == DACC);
  // Normal write completions leave dload alone; forced completions always return the error pattern.
  assign d_load_upd_s = d_done_s && (done_to_s || !dWEN);
  assign ret_data_s   = done_to_s ? BAD_WORD : ramload;

  // State register.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: the grant is decided in IDLE and registered, and every access returns to IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        // After a data completion a waiting instruction read gets the next grant.
        if (dreq_s && !(last_d_r && iREN)) begin
          state_next_s = DACC;
        end else if (iREN) begin
          state_next_s = IACC;
        end else begin
          state_next_s = IDLE;
        end
      end
      IACC: begin
        if (!iREN || i_done_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = IACC;
        end
      end
      DACC: begin
        if (!dreq_s || d_done_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DACC;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Output decode: the RAM strobes follow the state, and the waits/loads/error respond within the cycle.
  always_comb begin
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = {ADDR_W{1'b0}};
    ramstore    = {DATA_W{1'b0}};
    iwait       = !i_done_s;
    dwait       = !d_done_s;
    timeout_err = done_to_s;
    iload       = iload_r;
    dload       = dload_r;
    case (state_r)
      IACC: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
      end
      DACC: begin
        ramaddr = daddr;
        // The live dWEN picks the strobe, so a switch from write to read re-decodes it.
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else begin
          ramREN = 1'b1;
        end
      end
      default: begin
        ramREN  = 1'b0;
        ramWEN  = 1'b0;
      end
    endcase
    if (i_done_s) begin
      iload = ret_data_s;
    end else begin
      iload = iload_r;
    end
    if (d_load_upd_s) begin
      dload = ret_data_s;
    end else begin
      dload = dload_r;
    end
  end

  // Held load data, fairness flag and timeout counter.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      iload_r  <= {DATA_W{1'b0}};
      dload_r  <= {DATA_W{1'b0}};
      last_d_r <= 1'b0;
      tcnt_r   <= {TCNT_W{1'b0}};
    end else begin
      if (i_done_s) begin
        iload_r <= ret_data_s;
      end
      if (d_load_upd_s) begin
        dload_r <= ret_data_s;
      end
      if (i_done_s || d_done_s) begin
        last_d_r <= (state_r == DACC);
      end
      // The counter runs only while a live access waits. It clears on completion, withdrawal and in IDLE.
      if (!active_s || i_done_s || d_done_s) begin
        tcnt_r <= {TCNT_W{1'b0}};
      end else begin
        tcnt_r <= tcnt_r + TCNT_W'(1);
      end
    end
  end

`ifdef ACCESS_COUNT_EN
  logic [31:0] icount_r;
  logic [31:0] dcount_r;

  // Completion counters, including timeouts. They wrap naturally at 32 bits.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      icount_r <= 32'd0;
      dcount_r <= 32'd0;
    end else begin
      if (i_done_s) begin
        icount_r <= icount_r + 32'd1;
      end
      if (d_done_s) begin
        dcount_r <= dcount_r + 32'd1;
      end
    end
  end

  assign icount = icount_r;
  assign dcount = dcount_r;
`endif

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Self-checking bench for cache_mem_ctrl. Expected completions are queued as
// the stimulus is driven. A monitor pops them when iwait or dwait drops. The
// scenario tasks also check the per-cycle strobe, address and wait values.
module tb_cache_mem_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          CLK;
  logic          nRST;
  logic          iREN;
  logic [AW-1:0] iaddr;
  logic          dREN;
  logic          dWEN;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dstore;
  logic          iwait;
  logic          dwait;
  logic [DW-1:0] iload;
  logic [DW-1:0] dload;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload;
  logic          ram_ready;
  logic          timeout_err;
`ifdef ACCESS_COUNT_EN
  logic [31:0]   icount;
  logic [31:0]   dcount;
`endif

  typedef struct {
    logic          side_d;
    logic [DW-1:0] data;
    logic          to;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic mon_d;
  logic [DW-1:0] mon_data;
  int checks = 0;
  int errors = 0;
  int n_i = 0;
  int n_d = 0;

  cache_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait), .iload(iload),
    .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ram_ready(ram_ready),
`ifdef ACCESS_COUNT_EN
    .icount(icount), .dcount(dcount),
`endif
    .timeout_err(timeout_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, required summary before it");
    $fatal(1);
  end

  function automatic exp_t mk_exp(input logic s, input logic [DW-1:0] d, input logic t);
    exp_t e;
    e.side_d = s;
    e.data   = d;
    e.to     = t;
    return e;
  endfunction

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard monitor: checks strobe exclusivity every cycle and matches each completion against the queue.
  always @(negedge CLK) begin
    checks++;
    if ((ramREN && ramWEN) !== 1'b0) begin
      errors++;
      $display("FAIL strobe_excl ramREN=%b ramWEN=%b required not both 1", ramREN, ramWEN);
    end
    if (iwait !== 1'b1 || dwait !== 1'b1) begin
      checks++;
      if (iwait !== 1'b1 && dwait !== 1'b1) begin
        errors++;
        $display("FAIL wait_excl iwait=%b dwait=%b required at most one 0", iwait, dwait);
      end else if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_completion iwait=%b dwait=%b required none", iwait, dwait);
      end else begin
        mon_e    = sb_q.pop_front();
        mon_d    = (dwait !== 1'b1);
        mon_data = mon_d ? dload : iload;
        if (mon_d !== mon_e.side_d || mon_data !== mon_e.data || timeout_err !== mon_e.to) begin
          errors++;
          $display("FAIL completion side_d=%b data=%h terr=%b required side_d=%b data=%h terr=%b",
                   mon_d, mon_data, timeout_err, mon_e.side_d, mon_e.data, mon_e.to);
        end
      end
    end
  end

  task automatic test_reset();
    nRST = 1'b0; iREN = 1'b1; dWEN = 1'b1; dREN = 1'b0;
    iaddr = 32'h40; daddr = 32'h200; dstore = 32'h55; ram_ready = 1'b0; ramload = 32'h0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      checks++;
      if ({iwait, dwait, ramREN, ramWEN, timeout_err} !== 5'b11000) begin
        errors++;
        $display("FAIL reset_ctrl cyc=%0d got=%b required=11000", c,
                 {iwait, dwait, ramREN, ramWEN, timeout_err});
      end
      checks++;
      if (ramaddr !== 32'h0 || ramstore !== 32'h0 || iload !== 32'h0 || dload !== 32'h0) begin
        errors++;
        $display("FAIL reset_data addr=%h store=%h iload=%h dload=%h required all 0",
                 ramaddr, ramstore, iload, dload);
      end
      next_cycle();
    end
    nRST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({ramREN, ramWEN} !== 2'b00) begin
      errors++;
      $display("FAIL release_idle strobes=%b required 00", {ramREN, ramWEN});
    end
    next_cycle();
    @(negedge CLK);
    checks++;
    if ({ramWEN, ramREN, dwait, iwait} !== 4'b1011 || ramaddr !== 32'h200 || ramstore !== 32'h55) begin
      errors++;
      $display("FAIL first_grant wen/ren/dw/iw=%b addr=%h store=%h required 1011 200 55",
               {ramWEN, ramREN, dwait, iwait}, ramaddr, ramstore);
    end
    next_cycle();
    ram_ready = 1'b1; ramload = 32'hFEEDFACE; nRST = 1'b0;
    @(negedge CLK);
    checks++;
    if ({dwait, iwait} !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid_dacc dwait/iwait=%b required 11", {dwait, iwait});
    end
    next_cycle();
    nRST = 1'b1; ram_ready = 1'b0; iREN = 1'b0; dWEN = 1'b0;
    @(negedge CLK);
    checks++;
    if ({ramREN, ramWEN} !== 2'b00 || dload !== 32'h0) begin
      errors++;
      $display("FAIL after_abort strobes=%b dload=%h required 00 0", {ramREN, ramWEN}, dload);
    end
    next_cycle();
  endtask

  task automatic test_iread();
    iREN = 1'b1; iaddr = 32'h100;
    sb_q.push_back(mk_exp(1'b0, 32'hDEADBEEF, 1'b0)); n_i++;
    @(negedge CLK);
    checks++;
    if ({ramREN, iwait} !== 2'b01) begin
      errors++;
      $display("FAIL iread_latency ren/iwait=%b required 01", {ramREN, iwait});
    end
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      checks++;
      if ({ramREN, ramWEN, iwait} !== 3'b101 || ramaddr !== 32'h100) begin
        errors++;
        $display("FAIL iread_wait cyc=%0d ren/wen/iw=%b addr=%h required 101 100", c,
                 {ramREN, ramWEN, iwait}, ramaddr);
      end
      next_cycle();
    end
    ram_ready = 1'b1; ramload = 32'hDEADBEEF;
    @(negedge CLK);
    checks++;
    if ({iwait, ramREN, timeout_err} !== 3'b010 || iload !== 32'hDEADBEEF || ramaddr !== 32'h100) begin
      errors++;
      $display("FAIL iread_done iw/ren/terr=%b iload=%h addr=%h required 010 deadbeef 100",
               {iwait, ramREN, timeout_err}, iload, ramaddr);
    end
    next_cycle();
    iREN = 1'b0; ram_ready = 1'b0; ramload = 32'h11111111;
    @(negedge CLK);
    checks++;
    if ({iwait, ramREN} !== 2'b10 || iload !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL iread_hold iw/ren=%b iload=%h required 10 deadbeef", {iwait, ramREN}, iload);
    end
    next_cycle();
  endtask

  task automatic test_contention();
    iREN = 1'b1; iaddr = 32'h40; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h1234;
    ram_ready = 1'b1; ramload = 32'hAAAA0000;
    sb_q.push_back(mk_exp(1'b1, 32'h0, 1'b0));
    sb_q.push_back(mk_exp(1'b0, 32'hAAAA0000, 1'b0));
    sb_q.push_back(mk_exp(1'b1, 32'h5555AAAA, 1'b0));
    n_d += 2; n_i++;
    @(negedge CLK);
    checks++;
    if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
      errors++;
      $display("FAIL cont_idle ren/wen/iw/dw=%b required 0011", {ramREN, ramWEN, iwait, dwait});
    end
    next_cycle();
    @(negedge CLK);
    checks++;
    if ({ramWEN, ramREN, dwait, iwait} !== 4'b1001 || ramaddr !== 32'h200 || ramstore !== 32'h1234
        || dload !== 32'h0) begin
      errors++;
      $display("FAIL cont_dwrite wen/ren/dw/iw=%b addr=%h store=%h dload=%h required 1001 200 1234 0",
               {ramWEN, ramREN, dwait, iwait}, ramaddr, ramstore, dload);
    end
    next_cycle();
    dWEN = 1'b0; dREN = 1'b1; daddr = 32'h300;
    @(negedge CLK);
    checks++;
    if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
      errors++;
      $display("FAIL cont_gap ren/wen/iw/dw=%b required 0011", {ramREN, ramWEN, iwait, dwait});
    end
    next_cycle();
    @(negedge CLK);
    checks++;
    if ({ramREN, iwait, dwait} !== 3'b101 || ramaddr !== 32'h40 || iload !== 32'hAAAA0000) begin
      errors++;
      $display("FAIL cont_ifirst ren/iw/dw=%b addr=%h iload=%h required 101 40 aaaa0000",
               {ramREN, iwait, dwait}, ramaddr, iload);
    end
    next_cycle();
    iREN = 1'b0; ramload = 32'h5555AAAA;
    @(negedge CLK);
    checks++;
    if ({ramREN, ramWEN} !== 2'b00) begin
      errors++;
      $display("FAIL cont_gap2 strobes=%b required 00", {ramREN, ramWEN});
    end
    next_cycle();
    @(negedge CLK);
    checks++;
    if ({ramREN, dwait} !== 2'b10 || ramaddr !== 32'h300 || dload !== 32'h5555AAAA) begin
      errors++;
      $display("FAIL cont_dread ren/dw=%b addr=%h dload=%h required 10 300 5555aaaa",
               {ramREN, dwait}, ramaddr, dload);
    end
    next_cycle();
    dREN = 1'b0; ram_ready = 1'b0;
    next_cycle();
  endtask

  task automatic test_timeout();
    dREN = 1'b1; daddr = 32'h80; ram_ready = 1'b0;
    sb_q.push_back(mk_exp(1'b1, 32'hBAD1BAD1, 1'b1)); n_d++;
    next_cycle();
    for (int c = 1; c < 4; c++) begin
      @(negedge CLK);
      checks++;
      if ({ramREN, dwait, timeout_err} !== 3'b110 || ramaddr !== 32'h80) begin
        errors++;
        $display("FAIL to_wait cyc=%0d ren/dw/terr=%b addr=%h required 110 80", c,
                 {ramREN, dwait, timeout_err}, ramaddr);
      end
      next_cycle();
    end
    @(negedge CLK);
    checks++;
    if ({dwait, timeout_err} !== 2'b01 || dload !== 32'hBAD1BAD1) begin
      errors++;
      $display("FAIL to_done dw/terr=%b dload=%h required 01 bad1bad1", {dwait, timeout_err}, dload);
    end
    next_cycle();
    dREN = 1'b0;
    @(negedge CLK);
    checks++;
    if ({dwait, timeout_err} !== 2'b10 || dload !== 32'hBAD1BAD1) begin
      errors++;
      $display("FAIL to_after dw/terr=%b dload=%h required 10 bad1bad1", {dwait, timeout_err}, dload);
    end
    next_cycle();
    dREN = 1'b1; daddr = 32'h84;
    sb_q.push_back(mk_exp(1'b1, 32'h0BADF00D, 1'b0)); n_d++;
    repeat (4) next_cycle();
    ram_ready = 1'b1; ramload = 32'h0BADF00D;
    @(negedge CLK);
    checks++;
    if ({dwait, timeout_err} !== 2'b00 || dload !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL to_race dw/terr=%b dload=%h required 00 0badf00d", {dwait, timeout_err}, dload);
    end
    next_cycle();
    dREN = 1'b0; ram_ready = 1'b0;
    next_cycle();
  endtask

  task automatic test_withdraw();
    iREN = 1'b1; iaddr = 32'h140; ram_ready = 1'b0;
    next_cycle();
    @(negedge CLK);
    checks++;
    if ({ramREN, iwait} !== 2'b11) begin
      errors++;
      $display("FAIL wd_iacc ren/iw=%b required 11", {ramREN, iwait});
    end
    next_cycle();
    iREN = 1'b0;
    @(negedge CLK);
    checks++;
    if (iwait !== 1'b1) begin
      errors++;
      $display("FAIL wd_drop iwait=%b required 1", iwait);
    end
    next_cycle();
    @(negedge CLK);
    checks++;
    if ({ramREN, iwait} !== 2'b01) begin
      errors++;
      $display("FAIL wd_idle ren/iw=%b required 01", {ramREN, iwait});
    end
    next_cycle();
    iREN = 1'b1; iaddr = 32'h144;
    sb_q.push_back(mk_exp(1'b0, 32'hBAD1BAD1, 1'b1)); n_i++;
    next_cycle();
    for (int c = 1; c < 4; c++) begin
      @(negedge CLK);
      checks++;
      if ({iwait, timeout_err} !== 2'b10) begin
        errors++;
        $display("FAIL wd_tcnt_clear cyc=%0d iw/terr=%b required 10", c, {iwait, timeout_err});
      end
      next_cycle();
    end
    @(negedge CLK);
    checks++;
    if ({iwait, timeout_err} !== 2'b01 || iload !== 32'hBAD1BAD1) begin
      errors++;
      $display("FAIL wd_to iw/terr=%b iload=%h required 01 bad1bad1", {iwait, timeout_err}, iload);
    end
    next_cycle();
    iREN = 1'b0;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_iread();
    test_contention();
    test_timeout();
    test_withdraw();
    @(negedge CLK);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain pending=%0d required 0", sb_q.size());
    end
`ifdef ACCESS_COUNT_EN
    checks++;
    if (icount !== 32'(n_i) || dcount !== 32'(n_d)) begin
      errors++;
      $display("FAIL counts icount=%0d dcount=%0d required %0d %0d", icount, dcount, n_i, n_d);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
